// File: rtl/tt_uart_pkg.sv
// Shared types and constants for the tt_um_prueba UART paths.
package tt_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/tt_sync_ff.sv
// N-flop synchronizer for asynchronous pins; flops reset to 1 so an idle-high
// line never shows a false edge coming out of reset.
module tt_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/tt_uart_rx.sv
// 8N1 UART receiver: oversampled deframer with valid/rd handshake,
// framing-error pulse and sticky overrun flag.
module tt_uart_rx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  tt_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = ovr_q;

    if (valid_q && rd) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            // A start bit that is high again at its midpoint was a glitch.
            if (!rx_s) begin
              state_d = DATA;
              idx_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            // A completing byte overrides a same-cycle rd and is not an overrun.
            if (rx_s) begin
              data_out_d = shift_q;
              valid_d    = 1'b1;
              if (valid_q && !rd) begin
                ovr_d = 1'b1;
              end
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tt_uart_rx.sv
// Scoreboard bench for tt_uart_rx: frames are driven on rx, expected outcomes
// queued, and a monitor matches each byte/frame-error the DUT presents.
module tb_tt_uart_rx;

  localparam int CPB = 16;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       rx;
  logic       rd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   vectors;
  int   miscompares;
  exp_t exp_q[$];
  bit   auto_rd;
  logic valid_153;
  logic valid_158;

  logic       mon_prev_valid;
  logic       mon_prev_ferr;
  logic [7:0] mon_prev_data;

  tt_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rx        (rx),
    .rd        (rd),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'h00);
    check({tag, "_data_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame of 10*CPB cycles; abort_at drops ena, rst_at pulses rst_n.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_it,
                            input int abort_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    if (expect_it) begin
      exp_t e;
      e.is_err = !stop_bit;
      e.data   = b;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == 153) valid_153 = data_valid;
      if (c == 158) valid_158 = data_valid;
      rx = bits[c / CPB];
      if (c == abort_at) ena = 1'b0;
      if (abort_at >= 0 && c == abort_at + 1) check("busy_ena_low", 32'(busy), 32'h0);
      if (c == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && c == rst_at + 1) begin
        check_reset_values("midframe_rst");
        rst_n = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pop_expect(input bit got_err, input logic [7:0] got_data);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL spurious_event: got err=%0d data=0x%02h, required no event", got_err, got_data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind_is_err", 32'(got_err), 32'(e.is_err));
      if (!e.is_err && !got_err) begin
        check("byte_data", 32'(got_data), 32'(e.data));
        $display("rx byte 0x%02h expected 0x%02h", got_data, e.data);
      end else begin
        $display("rx frame error event (expected err=%0d)", e.is_err);
      end
    end
  endtask

  // Monitor: a new byte is a rising data_valid or a data_out change while valid.
  initial begin
    mon_prev_valid = 1'b0;
    mon_prev_ferr  = 1'b0;
    mon_prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (frame_err) begin
        if (mon_prev_ferr) check("frame_err_width", 32'(mon_prev_ferr), 32'h0);
        else pop_expect(1'b1, 8'h00);
      end
      if (data_valid && (!mon_prev_valid || data_out != mon_prev_data)) begin
        pop_expect(1'b0, data_out);
      end
      mon_prev_valid = data_valid;
      mon_prev_ferr  = frame_err;
      mon_prev_data  = data_out;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (auto_rd && data_valid) begin
        repeat ($urandom_range(0, 15)) @(negedge clk);
        pulse_rd();
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit last_bad;
    logic [7:0] b;
    logic sb;
    vectors     = 0;
    miscompares = 0;
    auto_rd     = 1'b0;
    rst_n       = 1'b0;
    ena         = 1'b1;
    rx          = 1'b1;
    rd          = 1'b0;

    repeat (5) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    idle(20);

    // Good frame, held without rd, then consumed.
    send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
    check("latency_valid_c153", 32'(valid_153), 32'h0);
    check("latency_valid_c158", 32'(valid_158), 32'h1);
    idle(20);
    check("a5_data_out", 32'(data_out), 32'hA5);
    check("a5_valid_held", 32'(data_valid), 32'h1);
    check("a5_overrun", 32'(overrun), 32'h0);
    pulse_rd();
    check("a5_valid_after_rd", 32'(data_valid), 32'h0);
    check("a5_data_after_rd", 32'(data_out), 32'hA5);
    idle(10);

    // Framing error keeps the last good byte and valid low.
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1);
    idle(30);
    check("ferr_valid", 32'(data_valid), 32'h0);
    check("ferr_data_out", 32'(data_out), 32'hA5);
    check("ferr_overrun", 32'(overrun), 32'h0);

    // Short low glitch on the line.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_high", 32'(busy), 32'h1);
    idle(20);
    check("glitch_busy_low", 32'(busy), 32'h0);
    check("glitch_valid", 32'(data_valid), 32'h0);

    // Back-to-back frames with no rd produce an overrun.
    send_frame(8'h11, 1'b1, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1, -1);
    idle(10);
    check("b2b_data_out", 32'(data_out), 32'h22);
    check("b2b_valid", 32'(data_valid), 32'h1);
    check("b2b_overrun", 32'(overrun), 32'h1);
    pulse_rd();
    check("b2b_valid_after_rd", 32'(data_valid), 32'h0);
    check("b2b_overrun_after_rd", 32'(overrun), 32'h0);
    idle(10);

    // ena dropped in the middle of data bit 4.
    send_frame(8'h55, 1'b1, 1'b0, 5 * CPB + 8, -1);
    idle(20);
    check("ena_low_valid", 32'(data_valid), 32'h0);
    ena = 1'b1;
    idle(10);
    send_frame(8'h0F, 1'b1, 1'b1, -1, -1);
    idle(10);
    check("ena_restored_data", 32'(data_out), 32'h0F);
    check("ena_restored_valid", 32'(data_valid), 32'h1);

    // Reset pulse in the middle of a frame.
    send_frame(8'hFF, 1'b1, 1'b0, -1, 5 * CPB);
    idle(10);
    send_frame(8'h81, 1'b1, 1'b1, -1, -1);
    idle(10);
    check("post_rst_data", 32'(data_out), 32'h81);
    check("post_rst_valid", 32'(data_valid), 32'h1);
    check("post_rst_overrun", 32'(overrun), 32'h0);

    // Random frames with an auto-consumer.
    auto_rd  = 1'b1;
    last_bad = 1'b0;
    idle(40);
    for (int n = 0; n < 30; n++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 4) != 0);
      if (last_bad) idle($urandom_range(20, 40));
      else idle($urandom_range(0, 30));
      send_frame(b, sb, 1'b1, -1, -1);
      last_bad = !sb;
    end
    idle(200);
    auto_rd = 1'b0;
    check("random_overrun", 32'(overrun), 32'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
